// File: rtl/div_rr_sched_pkg.sv
// div_rr_sched_pkg: shared state encoding, default sizes and fixed-point helpers for the divider scheduler
package div_rr_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int W_DEF     = 9;
    localparam int ITERS_DEF = 3;

    function automatic int one_frac(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int two_frac(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational Goldschmidt step, x and t both scaled by f = 2 - t
module div_iter_step
    import div_rr_sched_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W:0] x,
    input  logic [W:0] t,
    output logic [W:0] x_nxt,
    output logic [W:0] t_nxt
);

    localparam logic [W:0] TWO = (W+1)'(two_frac(W));

    logic [W:0]     f;
    logic [2*W+1:0] px;
    logic [2*W+1:0] pt;

    assign f     = TWO - t;
    assign px    = {{(W+1){1'b0}}, x} * {{(W+1){1'b0}}, f};
    assign pt    = {{(W+1){1'b0}}, t} * {{(W+1){1'b0}}, f};
    assign x_nxt = (W+1)'(px >> (W - 1));
    assign t_nxt = (W+1)'(pt >> (W - 1));

endmodule

// File: rtl/div_rr_sched.sv
// div_rr_sched: round-robin scheduler time-sharing one Goldschmidt divider among NREQ requesters
module div_rr_sched
    import div_rr_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int W     = W_DEF,
    parameter int ITERS = ITERS_DEF,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] n_in,
    input  logic [NREQ*W-1:0] d_in,
    output logic [W-1:0]      q_out,
    output logic [IDW-1:0]    q_id,
    output logic              q_dz,
    output logic              q_valid,
    input  logic              q_ready,
    output logic              busy
);

    localparam int CW = $clog2(ITERS + 1);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_idx;
    logic            any_vld;
    logic [IDW-1:0]  id;
    logic            dz;
    logic [CW-1:0]   cnt;
    logic            last;
    logic [W:0]      x;
    logic [W:0]      t;
    logic [W:0]      x_nxt;
    logic [W:0]      t_nxt;
    logic [W-1:0]    n_sel;
    logic [W-1:0]    d_sel;

    div_iter_step #(.W(W)) u_step (
        .x     (x),
        .t     (t),
        .x_nxt (x_nxt),
        .t_nxt (t_nxt)
    );

    // pick the first valid requester after ptr; scanning offsets downward leaves the nearest one winning
    always_comb begin
        gnt_idx = '0;
        any_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr) + k) % NREQ]) begin
                gnt_idx = IDW'((int'(ptr) + k) % NREQ);
                any_vld = 1'b1;
            end
        end
    end

    assign req_ready = (state == S_IDLE && any_vld) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx : '0;
    assign busy      = state != S_IDLE;
    assign last      = state == S_ITER && cnt == CW'(ITERS - 1);
    assign n_sel     = n_in[int'(gnt_idx)*W +: W];
    assign d_sel     = d_in[int'(gnt_idx)*W +: W];

    // next-state: grant leaves IDLE, the final step enters DONE, downstream acceptance returns to IDLE
    always_comb begin
        state_nxt = state;
        state_nxt = state == S_IDLE ? (any_vld ? S_ITER : S_IDLE) :
                    state == S_ITER ? (last ? S_DONE : S_ITER) :
                    (q_ready ? S_IDLE : S_DONE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // operand capture, iteration datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            x       <= '0;
            t       <= '0;
            id      <= '0;
            dz      <= 1'b0;
            cnt     <= '0;
            ptr     <= IDW'(NREQ - 1);
            q_out   <= '0;
            q_id    <= '0;
            q_dz    <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (any_vld) begin
                    x   <= {1'b0, n_sel};
                    t   <= {1'b0, d_sel};
                    id  <= gnt_idx;
                    ptr <= gnt_idx;
                    dz  <= d_sel == '0;
                    cnt <= '0;
                end
                S_ITER: begin
                    x   <= x_nxt;
                    t   <= t_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        q_valid <= 1'b1;
                        q_out   <= dz ? {W{1'b1}} : x_nxt[W-1:0];
                        q_id    <= id;
                        q_dz    <= dz;
                    end
                end
                S_DONE: if (q_ready) q_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_rr_sched.sv
// tb_div_rr_sched: scoreboard bench with a behavioural divider/arbiter model for div_rr_sched
module tb_div_rr_sched;

    localparam int NREQ  = 4;
    localparam int W     = 9;
    localparam int ITERS = 3;
    localparam int IDW   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] n_in = '0;
    logic [NREQ*W-1:0] d_in = '0;
    logic [W-1:0]      q_out;
    logic [IDW-1:0]    q_id;
    logic              q_dz;
    logic              q_valid;
    logic              q_ready = 1'b0;
    logic              busy;

    div_rr_sched #(.NREQ(NREQ), .W(W), .ITERS(ITERS), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .n_in      (n_in),
        .d_in      (d_in),
        .q_out     (q_out),
        .q_id      (q_id),
        .q_dz      (q_dz),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int q;
        bit dz;
        int due;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   m_idle = 1'b1;
    int   mptr = NREQ - 1;
    int   last_q = -1;
    int   last_id = -1;
    int   last_dz = -1;
    int   acc_cyc[$];
    int   acc_id[$];
    bit   prev_v = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Goldschmidt quotient from the arithmetic definition: scale both by (2 - t) ITERS times
    function automatic int ref_div(input int n, input int d);
        longint x = n;
        longint t = d;
        longint f;
        longint m = (64'd1 << (W + 1)) - 1;
        if (d == 0) return (1 << W) - 1;
        for (int i = 0; i < ITERS; i++) begin
            f = ((64'd1 << W) - t) & m;
            x = ((x * f) >> (W - 1)) & m;
            t = ((t * f) >> (W - 1)) & m;
        end
        return int'(x & ((64'd1 << W) - 1));
    endfunction

    // arbiter model: predict the grant each idle cycle and enqueue the expected result
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] er;
        if (reset) begin
            m_idle = 1'b1;
            mptr = NREQ - 1;
            sbq.delete();
        end else begin
            g = -1;
            er = '0;
            if (m_idle)
                for (int k = 1; k <= NREQ; k++)
                    if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("busy", 64'(busy), 64'(!m_idle));
            if (q_valid && q_ready) m_idle = 1'b1;
            if (g >= 0) begin
                sbq.push_back('{g, ref_div(int'(n_in[g*W +: W]), int'(d_in[g*W +: W])),
                                d_in[g*W +: W] == 0, cyc + ITERS + 1});
                mptr = g;
                m_idle = 1'b0;
            end
        end
    end

    // result monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        if (reset) prev_v = 1'b0;
        else begin
            if (q_valid) begin
                if (sbq.size() == 0) chk("unexpected q_valid", 64'(q_valid), 64'd0);
                else begin
                    if (!prev_v) chk("latency", 64'(cyc), 64'(sbq[0].due));
                    chk("q_out", 64'(q_out), 64'(sbq[0].q));
                    chk("q_id", 64'(q_id), 64'(sbq[0].id));
                    chk("q_dz", 64'(q_dz), 64'(sbq[0].dz));
                    if (q_ready) begin
                        last_q = int'(q_out);
                        last_id = int'(q_id);
                        last_dz = int'(q_dz);
                        acc_cyc.push_back(cyc);
                        acc_id.push_back(int'(q_id));
                        void'(sbq.pop_front());
                    end
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                chk("result timeout", 64'd0, 64'd1);
                void'(sbq.pop_front());
            end
            prev_v = q_valid && !q_ready;
        end
    end

    task automatic req_one(input int i, input int n, input int d);
        bit hit = 1'b0;
        @(posedge clk); #1;
        n_in[i*W +: W] = W'(n);
        d_in[i*W +: W] = W'(d);
        req_valid[i] = 1'b1;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            hit = req_ready[i];
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        n_in[i*W +: W] = W'($urandom);
        d_in[i*W +: W] = W'($urandom);
        if (!hit) chk("grant timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !q_valid) return;
        end
        chk("drain timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " q_valid"}, 64'(q_valid), 64'd0);
        chk({tag, " q_out"}, 64'(q_out), 64'd0);
        chk({tag, " q_id"}, 64'(q_id), 64'd0);
        chk({tag, " q_dz"}, 64'(q_dz), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " req_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        int c0;
        bit seen;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        q_ready = 1'b1;
        req_one(0, 128, 192);
        drain();
        chk("single q_out", 64'(last_q), 64'd170);
        chk("single q_id", 64'(last_id), 64'd0);
        chk("single q_dz", 64'(last_dz), 64'd0);

        req_one(3, 100, 256);
        drain();
        chk("identity q_out", 64'(last_q), 64'd100);

        req_one(2, 50, 0);
        drain();
        chk("dz q_out", 64'(last_q), 64'd511);
        chk("dz q_id", 64'(last_id), 64'd2);
        chk("dz q_dz", 64'(last_dz), 64'd1);

        q_ready = 1'b0;
        req_one(1, 77, 200);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = q_valid;
        end
        chk("backpressure q_valid", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        q_ready = 1'b1;
        c0 = cyc;
        drain();
        chk("backpressure accept cycle", 64'(acc_cyc.size() > 0 ? acc_cyc[$] : -1), 64'(c0));

        req_one(1, 90, 180);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_zero("mid reset");
        @(posedge clk); #1;
        n_in[0 +: W] = W'(60);
        d_in[0 +: W] = W'(150);
        n_in[W +: W] = W'(70);
        d_in[W +: W] = W'(160);
        req_valid[1:0] = 2'b11;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int c = 0; c < 10 && req_valid[1]; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                @(posedge clk); #1;
                req_valid[1] = 1'b0;
            end
        end
        req_valid = '0;
        drain();
        chk("post reset first id", 64'(acc_id.size() >= 2 ? acc_id[acc_id.size()-2] : -1), 64'd0);

        acc_id.delete();
        acc_cyc.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = '1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 21; c++) begin
            @(posedge clk); #1;
            n_in = {NREQ{W'($urandom)}} ^ (NREQ*W)'($urandom);
            for (int i = 0; i < NREQ; i++) d_in[i*W +: W] = W'($urandom_range(128, 256));
        end
        req_valid = '0;
        drain();
        chk("fairness count", 64'(acc_id.size()), 64'd5);
        if (acc_id.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("fairness id", 64'(acc_id[i]), 64'(i % NREQ));
            for (int i = 1; i < 5; i++) chk("fairness spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(ITERS + 2));
        end

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            q_ready = ($urandom % 4) != 0;
            for (int i = 0; i < NREQ; i++) begin
                int p = $urandom % 10;
                n_in[i*W +: W] = W'($urandom);
                d_in[i*W +: W] = p == 0 ? W'(0) : p == 1 ? W'($urandom_range(1, 127)) : W'($urandom_range(128, 256));
            end
        end
        req_valid = '0;
        q_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
